// File: rtl/canny_stream_out.sv
// AXI4-Stream output stage for the edge pipeline: a first-word-fall-through FIFO
// that tags frame/line boundaries and records pixels dropped while the FIFO is full.
module canny_stream_out #(
  parameter int unsigned IMG_WIDTH  = 512,
  parameter int unsigned IMG_HEIGHT = 512,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    pixel_in,
  input  logic                          pixel_in_valid,
  output logic [7:0]                    m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tuser,
  output logic                          m_axis_tlast,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int unsigned ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = AW + 1;

  typedef struct packed {
    logic       eof;
    logic       sof;
    logic       eol;
    logic [7:0] data;
  } entry_t;

  entry_t             mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               overflow_q, overflow_d;
  logic               frame_done_q, frame_done_d;

  entry_t             head;
  entry_t             wr_entry;
  logic               push;
  logic               pop;
  logic               last_col;
  logic               last_row;

  assign head     = mem_q[rd_ptr_q];
  assign last_col = (col_q == COL_W'(IMG_WIDTH - 1));
  assign last_row = (row_q == ROW_W'(IMG_HEIGHT - 1));
  assign pop      = (level_q != '0) && m_axis_tready;
  // A full FIFO still accepts a pixel when the head leaves on the same edge.
  assign push     = pixel_in_valid && ((level_q != LVL_W'(FIFO_DEPTH)) || pop);

  always_comb begin
    wr_entry      = '0;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    col_d         = col_q;
    row_d         = row_q;
    overflow_d    = overflow_q;
    frame_done_d  = 1'b0;

    wr_entry.data = pixel_in;
    wr_entry.sof  = (col_q == '0) && (row_q == '0);
    wr_entry.eol  = last_col;
    wr_entry.eof  = last_col && last_row;

    // Position tracks every valid input, dropped or not, so framing stays aligned.
    if (pixel_in_valid) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      if (!push) overflow_d = 1'b1;
    end

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop) begin
      rd_ptr_d     = rd_ptr_q + AW'(1);
      frame_done_d = head.eof;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      col_q        <= '0;
      row_q        <= '0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      col_q        <= col_d;
      row_q        <= row_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Storage needs no reset: it is never observed while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

  // Head fields are forced to zero while empty so nothing stale is presented.
  assign m_axis_tvalid = (level_q != '0);
  assign m_axis_tdata  = m_axis_tvalid ? head.data : 8'h00;
  assign m_axis_tuser  = m_axis_tvalid & head.sof;
  assign m_axis_tlast  = m_axis_tvalid & head.eol;
  assign frame_done    = frame_done_q;
  assign overflow      = overflow_q;
  assign fifo_level    = level_q;

endmodule

// File: tb/tb_canny_stream_out.sv
// Scoreboard bench for canny_stream_out: the driver models acceptance and framing,
// and a negedge monitor checks every beat and every frame_done cycle.
module tb_canny_stream_out;

  localparam int W = 4;
  localparam int H = 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] pixel_in = 8'h00;
  logic       pixel_in_valid = 1'b0;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready = 1'b0;
  logic       m_axis_tuser;
  logic       m_axis_tlast;
  logic       frame_done;
  logic       overflow;
  logic [2:0] fifo_level;

  canny_stream_out #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .pixel_in(pixel_in), .pixel_in_valid(pixel_in_valid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tuser(m_axis_tuser),
    .m_axis_tlast(m_axis_tlast), .frame_done(frame_done),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       sof;
    logic       eol;
    logic       eof;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   mlevel = 0;
  int   mcol = 0;
  int   mrow = 0;
  bit   fd_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge of stimulus; the model decides acceptance for that same edge.
  task automatic cyc(input bit v, input logic [7:0] d, input bit r);
    bit   pop;
    bit   push;
    exp_t e;
    @(posedge clk);
    #1;
    pixel_in_valid = v;
    pixel_in       = d;
    m_axis_tready  = r;
    pop  = (mlevel != 0) && r;
    push = v && ((mlevel < D) || pop);
    if (v) begin
      e.d   = d;
      e.sof = (mcol == 0) && (mrow == 0);
      e.eol = (mcol == W - 1);
      e.eof = e.eol && (mrow == H - 1);
      if (push) q.push_back(e);
      if (mcol == W - 1) begin
        mcol = 0;
        mrow = (mrow == H - 1) ? 0 : mrow + 1;
      end else begin
        mcol++;
      end
    end
    mlevel = mlevel + (push ? 1 : 0) - (pop ? 1 : 0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 50) begin
      cyc(1'b0, 8'h00, 1'b1);
      k++;
    end
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("drain_left", 32'(q.size()), 32'd0);
    @(negedge clk);
    chk("drain_level", 32'(fifo_level), 32'd0);
  endtask

  // Asserts reset between edges and checks outputs clear without waiting for a clock.
  task automatic do_reset();
    @(negedge clk);
    #2;
    pixel_in_valid = 1'b0;
    m_axis_tready  = 1'b0;
    rst = 1'b1;
    #1;
    chk("reset_outputs",
        32'({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, frame_done, overflow, fifo_level}),
        32'd0);
    q.delete();
    mlevel = 0;
    mcol   = 0;
    mrow   = 0;
    @(negedge clk);
    #2;
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      fd_pend = 1'b0;
    end else begin
      chk("frame_done", 32'(frame_done), 32'(fd_pend));
      fd_pend = 1'b0;
      if (m_axis_tvalid && m_axis_tready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 32'(m_axis_tdata), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          chk("tdata", 32'(m_axis_tdata), 32'(e.d));
          chk("tuser", 32'(m_axis_tuser), 32'(e.sof));
          chk("tlast", 32'(m_axis_tlast), 32'(e.eol));
          fd_pend = e.eof;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int guard;
    bit r;
    bit v;

    #3;
    chk("por_outputs",
        32'({m_axis_tvalid, m_axis_tdata, m_axis_tuser, m_axis_tlast, frame_done, overflow, fifo_level}),
        32'd0);
    do_reset();

    // Latency and tagging over one full frame.
    cyc(1'b1, 8'h10, 1'b1);
    @(negedge clk);
    chk("tvalid_before_write", 32'(m_axis_tvalid), 32'd0);
    cyc(1'b1, 8'h11, 1'b1);
    @(negedge clk);
    chk("tvalid_after_write", 32'(m_axis_tvalid), 32'd1);
    chk("first_data", 32'(m_axis_tdata), 32'h10);
    for (int i = 2; i < 8; i++) cyc(1'b1, 8'(8'h10 + i), 1'b1);
    drain();
    chk("overflow_clean", 32'(overflow), 32'd0);

    // Backpressure: data held stable until ready.
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("bp_level", 32'(fifo_level), 32'd4);
    chk("bp_tvalid", 32'(m_axis_tvalid), 32'd1);
    chk("bp_tdata", 32'(m_axis_tdata), 32'h20);
    cyc(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("bp_tdata_stable", 32'(m_axis_tdata), 32'h20);
    drain();

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h30 + i), 1'b0);
    cyc(1'b1, 8'h34, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("full_pushpop_level", 32'(fifo_level), 32'd4);
    chk("full_pushpop_ovf", 32'(overflow), 32'd0);
    drain();

    // Overflow: E and F dropped, framing continues.
    do_reset();
    for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("ovf_level", 32'(fifo_level), 32'd4);
    chk("ovf_flag", 32'(overflow), 32'd1);
    drain();
    cyc(1'b1, 8'hB2, 1'b1);
    cyc(1'b1, 8'hB3, 1'b1);
    drain();
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-frame with buffered data.
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("mid_level", 32'(fifo_level), 32'd3);
    do_reset();
    cyc(1'b1, 8'h55, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("post_reset_tuser", 32'(m_axis_tuser), 32'd1);
    chk("post_reset_tdata", 32'(m_axis_tdata), 32'h55);
    drain();

    // Three frames with random ready, kept below full.
    do_reset();
    n = 0;
    guard = 0;
    while (n < 3 * W * H && guard < 2000) begin
      r = ($urandom_range(0, 3) != 0);
      v = (mlevel < D - 1) && ($urandom_range(0, 1) == 1);
      if (v) begin
        cyc(1'b1, 8'(n * 7 + 3), r);
        n++;
      end else begin
        cyc(1'b0, 8'h00, r);
      end
      guard++;
    end
    chk("wrap_sent", 32'(n), 32'(3 * W * H));
    drain();
    chk("wrap_overflow", 32'(overflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
